// File: rtl/alu_pkg.sv
// Shared definitions for the sliced add/sub engine: op encoding, FSM state
// encoding and the default slice width.
package alu_pkg;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int ALU_SLICE_W_DEFAULT = 4;

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE_W-bit adder; inverts y when sub is set so the caller
// only has to supply the right carry/borrow-in.
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE_W = ALU_SLICE_W_DEFAULT
) (
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               c_in,
    input  logic               sub,
    output logic [SLICE_W-1:0] s,
    output logic               c_out
);

    logic [SLICE_W-1:0] y_eff;
    logic [SLICE_W:0]   sum;

    assign y_eff = (sub == ALU_SUB) ? ~y : y;
    assign sum   = {1'b0, x} + {1'b0, y_eff} + {{SLICE_W{1'b0}}, c_in};
    assign s     = sum[SLICE_W-1:0];
    assign c_out = sum[SLICE_W];

endmodule

// File: rtl/alu_chain_sequencer.sv
// Wide add/sub built from one narrow slice, one slice per cycle, LSB first.
// Define ALU_OVF_EN to add the signed-overflow output ovf.
module alu_chain_sequencer
    import alu_pkg::*;
#(
    parameter int SLICE_W = ALU_SLICE_W_DEFAULT,
    parameter int WORDS   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       op,
    input  logic [SLICE_W*WORDS-1:0]   a,
    input  logic [SLICE_W*WORDS-1:0]   b,
    input  logic                       cin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*WORDS-1:0]   result,
    output logic                       cout,
`ifdef ALU_OVF_EN
    output logic                       ovf,
`endif
    output logic                       zero
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    logic [1:0]                     state;
    logic                           armed;
    logic [IDX_W-1:0]               idx;
    logic [WORDS-1:0][SLICE_W-1:0]  a_q;
    logic [WORDS-1:0][SLICE_W-1:0]  b_q;
    logic [WORDS-1:0][SLICE_W-1:0]  res_q;
    logic                           op_q;
    logic                           carry;
    logic                           nz_seen;
    logic                           cout_q;
    logic                           zero_q;
    logic [SLICE_W-1:0]             s;
    logic                           c_out;
    logic                           accept;

    alu_slice #(.SLICE_W(SLICE_W)) u_slice (
        .x     (a_q[idx]),
        .y     (b_q[idx]),
        .c_in  (carry),
        .sub   (op_q),
        .s     (s),
        .c_out (c_out)
    );

    // armed keeps in_ready low until the first edge after reset release
    assign in_ready  = armed && (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign result    = res_q;
    assign cout      = cout_q;
    assign zero      = zero_q;

`ifdef ALU_OVF_EN
    logic ovf_q;
    logic msb_x;
    logic msb_y;

    // Same-sign operands giving a different-sign result is equivalent to
    // carry-into-MSB XOR carry-out-of-MSB.
    assign msb_x = a_q[idx][SLICE_W-1];
    assign msb_y = b_q[idx][SLICE_W-1] ^ op_q;
    assign ovf   = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if (state == S_RUN && idx == LAST_IDX) begin
            ovf_q <= (msb_x == msb_y) && (s[SLICE_W-1] != msb_x);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            armed   <= 1'b0;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= ALU_ADD;
            carry   <= 1'b0;
            nz_seen <= 1'b0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        carry   <= (op == ALU_SUB) ? ~cin : cin;
                        res_q   <= '0;
                        nz_seen <= 1'b0;
                        cout_q  <= 1'b0;
                        zero_q  <= 1'b0;
                        idx     <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_q[idx] <= s;
                    carry      <= c_out;
                    nz_seen    <= nz_seen | (|s);
                    if (idx == LAST_IDX) begin
                        cout_q <= c_out;
                        zero_q <= ~(nz_seen | (|s));
                        idx    <= '0;
                        state  <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_chain_sequencer.sv
// Directed bench for alu_chain_sequencer with an arithmetic reference model
// and a per-cycle compare process on the result handshake.
module tb_alu_chain_sequencer;

    localparam int SLICE_W = 4;
    localparam int WORDS   = 2;
    localparam int W       = SLICE_W * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
`ifdef ALU_OVF_EN
    logic         ovf;
`endif

    int passed = 0;
    int total  = 0;

    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_result;
    logic         exp_cout;
    logic         exp_zero;
    logic         exp_ovf;

    alu_chain_sequencer #(.SLICE_W(SLICE_W), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
`ifdef ALU_OVF_EN
        .ovf       (ovf),
`endif
        .zero      (zero)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input longint act, input longint exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: plain integer arithmetic on the full-width operands
    task automatic modelCompute(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                input logic ci);
        longint ua = longint'(av);
        longint ub = longint'(bv);
        longint sa = longint'($signed(av));
        longint sb = longint'($signed(bv));
        longint full;
        longint sres;
        longint smax = (longint'(1) <<< (W - 1)) - 1;
        longint smin = -(longint'(1) <<< (W - 1));
        if (o == 1'b0) begin
            full     = ua + ub + longint'(ci);
            sres     = sa + sb + longint'(ci);
            exp_cout = (full >= (longint'(1) <<< W));
        end else begin
            full     = ua - ub - longint'(ci);
            sres     = sa - sb - longint'(ci);
            exp_cout = (ua >= ub + longint'(ci));
        end
        exp_result = full[W-1:0];
        exp_zero   = (exp_result == '0);
        exp_ovf    = (sres > smax) || (sres < smin);
    endtask

    // Issue one request, scramble the inputs after acceptance, measure latency
    task automatic applyStimulus(input string name, input logic o, input logic [W-1:0] av,
                                 input logic [W-1:0] bv, input logic ci);
        int n = 0;
        int lat = 0;
        @(negedge clk);
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready"}, longint'(in_ready), 1);
        modelCompute(o, av, bv, ci);
        op = o; a = av; b = bv; cin = ci; in_valid = 1'b1;
        @(posedge clk);
        exp_valid = 1'b1;
        #1;
        in_valid = 1'b0; op = ~o; a = ~av; b = W'($urandom); cin = ~ci;
        while (!out_valid && lat < 2 * WORDS + 4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, longint'(lat), longint'(WORDS));
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] r, input logic c,
                               input logic z);
        check({name, "_result"}, longint'(result), longint'(r));
        check({name, "_cout"},   longint'(cout),   longint'(c));
        check({name, "_zero"},   longint'(zero),   longint'(z));
    endtask

    // Hold the result for some cycles while poking in_valid, then consume it
    task automatic releaseResult(input string name, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            a = W'($urandom);
            check({name, "_busy_ready"}, longint'(in_ready), 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        exp_valid = 1'b0;
        #1;
        out_ready = 1'b0;
        check({name, "_drop_valid"}, longint'(out_valid), 0);
        check({name, "_idle_ready"}, longint'(in_ready), 1);
    endtask

    // Compare process: every falling edge the result must match the model
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_valid && out_valid) begin
                check("stream_result", longint'(result), longint'(exp_result));
                check("stream_cout",   longint'(cout),   longint'(exp_cout));
                check("stream_zero",   longint'(zero),   longint'(exp_zero));
                check("stream_ready",  longint'(in_ready), 0);
`ifdef ALU_OVF_EN
                check("stream_ovf",    longint'(ovf),    longint'(exp_ovf));
`endif
            end else if (!exp_valid) begin
                check("stray_valid", longint'(out_valid), 0);
            end
        end
    end

    initial begin
        #2;
        check("rst_ready",  longint'(in_ready),  0);
        check("rst_valid",  longint'(out_valid), 0);
        check("rst_result", longint'(result),    0);
        check("rst_cout",   longint'(cout),      0);
        check("rst_zero",   longint'(zero),      0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rel_ready_low", longint'(in_ready), 0);
        @(posedge clk);
        #1;
        check("rel_ready_high", longint'(in_ready), 1);

        applyStimulus("add_d4_41", 1'b0, 8'hD4, 8'h41, 1'b0);
        checkOutput("add_d4_41", 8'h15, 1'b1, 1'b0);
        releaseResult("add_d4_41", 0);

        applyStimulus("add_fe_01", 1'b0, 8'hFE, 8'h01, 1'b1);
        checkOutput("add_fe_01", 8'h00, 1'b1, 1'b1);
        releaseResult("add_fe_01", 0);

        applyStimulus("sub_ee_ee", 1'b1, 8'hEE, 8'hEE, 1'b0);
        checkOutput("sub_ee_ee", 8'h00, 1'b1, 1'b1);
        releaseResult("sub_ee_ee", 0);

        applyStimulus("sub_0e_16", 1'b1, 8'h0E, 8'h16, 1'b0);
        checkOutput("sub_0e_16", 8'hF8, 1'b0, 1'b0);
        releaseResult("sub_0e_16", 5);

        applyStimulus("sub_bp_next", 1'b1, 8'h35, 8'h12, 1'b1);
        checkOutput("sub_bp_next", 8'h22, 1'b1, 1'b0);
        releaseResult("sub_bp_next", 1);

        // Abort mid-run: wait for accept, let slice 0 complete, then reset
        @(negedge clk);
        op = 1'b0; a = 8'h99; b = 8'h77; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_valid",  longint'(out_valid), 0);
        check("abort_result", longint'(result),    0);
        check("abort_ready",  longint'(in_ready),  0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_rel_ready", longint'(in_ready), 1);

        applyStimulus("add_01_01", 1'b0, 8'h01, 8'h01, 1'b0);
        checkOutput("add_01_01", 8'h02, 1'b0, 1'b0);
        releaseResult("add_01_01", 0);

`ifdef ALU_OVF_EN
        applyStimulus("ovf_add_7f", 1'b0, 8'h7F, 8'h01, 1'b0);
        checkOutput("ovf_add_7f", 8'h80, 1'b0, 1'b0);
        check("ovf_add_7f_ovf", longint'(ovf), 1);
        releaseResult("ovf_add_7f", 0);

        applyStimulus("ovf_sub_80", 1'b1, 8'h80, 8'h01, 1'b0);
        checkOutput("ovf_sub_80", 8'h7F, 1'b1, 1'b0);
        check("ovf_sub_80_ovf", longint'(ovf), 1);
        releaseResult("ovf_sub_80", 0);

        applyStimulus("ovf_add_10", 1'b0, 8'h10, 8'h10, 1'b0);
        checkOutput("ovf_add_10", 8'h20, 1'b0, 1'b0);
        check("ovf_add_10_ovf", longint'(ovf), 0);
        releaseResult("ovf_add_10", 0);
`endif

        for (int i = 0; i < 6; i++) begin
            applyStimulus("rand", 1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
            releaseResult("rand", i % 3);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
